// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate p = q*d + r (unsigned).
// Optional range check on the result and operands: MULADD_CHK_EN adds ovf.
module mul_add_seq #(
   parameter int WN = 8,
   parameter int WD = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WN-1:0]    q_in,
   input  logic [WD-1:0]    d_in,
   input  logic [WD-1:0]    r_in,
   output logic             busy,
   output logic             done,
   output logic [WN+WD-1:0] p_out
`ifdef MULADD_CHK_EN
   ,
   output logic             ovf
`endif
);

   localparam int WP = WN + WD;
   localparam int CW = (WN > 1) ? $clog2(WN) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [WN-1:0]   mq_q, mq_d;
   logic [WP-1:0]   md_q, md_d;
   logic [WP-1:0]   acc_q, acc_d;
   logic [WP-1:0]   p_q, p_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == CW'(WN - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      done  = done_q;
      p_out = p_q;
   end

   // Datapath: operands are latched on the start edge, so inputs may change after.
   always_comb begin
      mq_d   = mq_q;
      md_d   = md_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      p_d    = p_q;
      done_d = (state_q == DONE);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mq_d  = q_in;
               md_d  = {{WN{1'b0}}, d_in};
               acc_d = {{WN{1'b0}}, r_in};
               cnt_d = '0;
            end
         end
         RUN: begin
            if (mq_q[0]) acc_d = acc_q + md_q;
            mq_d  = mq_q >> 1;
            md_d  = md_q << 1;
            cnt_d = cnt_q + 1'b1;
         end
         DONE:    p_d = acc_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq_q   <= '0;
         md_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         p_q    <= '0;
         done_q <= 1'b0;
      end else begin
         mq_q   <= mq_d;
         md_q   <= md_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         done_q <= done_d;
      end
   end

`ifdef MULADD_CHK_EN
   // A legal divider triple has r < d and a numerator that fits in WN bits.
   logic [WD-1:0] rl_q, rl_d;
   logic [WD-1:0] dl_q, dl_d;
   logic          ovf_q, ovf_d;

   always_comb begin
      rl_d  = rl_q;
      dl_d  = dl_q;
      ovf_d = ovf_q;
      if (state_q == IDLE && start) begin
         rl_d = r_in;
         dl_d = d_in;
      end
      if (state_q == DONE) begin
         ovf_d = (rl_q >= dl_q) ||
                 (acc_q > {{WD{1'b0}}, {WN{1'b1}}});
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rl_q  <= '0;
         dl_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         rl_q  <= rl_d;
         dl_q  <= dl_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq: expected numerator and done cycle
// are queued at issue time and checked by an independent monitor.
module tb_mul_add_seq;

   localparam int WN = 8;
   localparam int WD = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [WN-1:0] q_in = '0;
   logic [WD-1:0] d_in = '0;
   logic [WD-1:0] r_in = '0;
   logic          busy;
   logic          done;
   logic [WN+WD-1:0] p_out;
`ifdef MULADD_CHK_EN
   logic          ovf;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      int p;
      bit ov;
      int at;
   } exp_t;

   exp_t sb[$];

   mul_add_seq #(.WN(WN), .WD(WD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .q_in    (q_in),
      .d_in    (d_in),
      .r_in    (r_in),
      .busy    (busy),
      .done    (done),
      .p_out   (p_out)
`ifdef MULADD_CHK_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding request.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done=1 want none (cycle %0d)",
                     cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("p_out", int'(p_out), e.p);
            chk("done_cycle", cyc, e.at);
`ifdef MULADD_CHK_EN
            chk("ovf", int'(ovf), int'(e.ov));
`endif
         end
      end
   end

   // Drive one request on the next falling edge; optionally expect a result.
   task automatic issue(input int q, input int d, input int r,
                        input int expv, input bit push);
      exp_t e;
      @(negedge clk);
      q_in  = WN'(q);
      d_in  = WD'(d);
      r_in  = WD'(r);
      start = 1'b1;
      if (push) begin
         e.p  = expv;
         e.ov = (r >= d) || (expv > (1 << WN) - 1);
         e.at = cyc + 1 + WN + 1;
         sb.push_back(e);
      end
   endtask

   task automatic drop_start();
      @(negedge clk);
      start = 1'b0;
      q_in  = WN'($urandom);
      d_in  = WD'($urandom);
      r_in  = WD'($urandom);
   endtask

   task automatic op(input int q, input int d, input int r);
      issue(q, d, r, q * d + r, 1'b1);
      drop_start();
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int n, d, q, r, wait_cnt;

      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_p", int'(p_out), 0);
`ifdef MULADD_CHK_EN
      chk("rst_ovf", int'(ovf), 0);
`endif
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      // Max operands, then boundary triples from the divider's range.
      op(255, 63, 62);
      chk("max_p", int'(p_out), 16127);
      op(36, 7, 3);
      op(0, 0, 5);
      op(17, 0, 9);
      op(0, 44, 20);

      // A second start while busy must be ignored.
      issue(3, 5, 1, 16, 1'b1);
      drop_start();
      repeat (2) @(negedge clk);
      q_in  = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("ignore_p", int'(p_out), 16);

      // Reset mid-operation aborts without a done pulse.
      issue(200, 40, 0, 0, 1'b0);
      drop_start();
      repeat (3) @(negedge clk);
      chk("pre_abort_busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_p", int'(p_out), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      op(12, 34, 5);

      // Random triples with random idle gaps.
      for (int i = 0; i < 8; i++) begin
         issue($urandom_range(0, 255), $urandom_range(0, 63),
               $urandom_range(0, 63), 0, 1'b0);
         sb.push_back('{int'(q_in) * int'(d_in) + int'(r_in),
                        (r_in >= d_in) ||
                        (int'(q_in) * int'(d_in) + int'(r_in) > 255),
                        cyc + 1 + WN + 1});
         drop_start();
         repeat (10 + $urandom_range(0, 4)) @(negedge clk);
      end

      // start held high: divider loopback, results every WN+2 cycles.
      for (int i = 0; i < 4; i++) begin
         n = $urandom_range(0, 255);
         d = $urandom_range(1, 63);
         q = n / d;
         r = n % d;
         issue(q, d, r, n, 1'b1);
         repeat (WN + 1) @(negedge clk);
      end
      start = 1'b0;

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      repeat (5) @(negedge clk);
      chk("final_busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
